seq_pair_monitor: RTL and testbench

//  Receive-side monitor for the XOR/registered-AND pair link (y1 = a^b combinational, y2 = a&b

---
 rtl/seq_pair_monitor.sv | 110 +++++++++++
 tb/tb_seq_pair_monitor.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pair_monitor.sv
// Receive-side monitor for the XOR / registered-AND pair link: re-aligns y1/y2 and counts pair classes per window.
// Optional macro SEQ_PAIR_MON_ERR_HALT_EN: the first illegal pair ends the window early.
module seq_pair_monitor #(
  parameter int unsigned WINDOW = 16,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             y1_in,
  input  logic             y2_in,
  input  logic             start,
  input  logic             rpt_ready,
  output logic             busy,
  output logic             rpt_valid,
  output logic [CNT_W-1:0] cnt_zero,
  output logic [CNT_W-1:0] cnt_one,
  output logic [CNT_W-1:0] cnt_diff,
  output logic [CNT_W-1:0] cnt_ill,
  output logic             err,
  output logic [1:0]       state_dbg
);

  // Report handshake: rpt_valid rises on entry to REPORT and stays high, with counts and err
  // frozen, until the cycle where rpt_valid && rpt_ready; the monitor is back in IDLE after that edge.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam logic [15:0]      WIN_LAST = 16'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t      state;
  state_t      state_nxt;
  logic        y1_d;
  logic [15:0] win_cnt;
  logic [1:0]  pair;

  // y1 of the previous cycle lines up with the y2 that arrives this cycle.
  assign pair      = {y1_d, y2_in};
  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = ACCUM;
      end
      ACCUM: begin
        if (win_cnt == WIN_LAST) state_nxt = REPORT;
`ifdef SEQ_PAIR_MON_ERR_HALT_EN
        if (pair == 2'b11) state_nxt = REPORT;
`endif
      end
      REPORT: begin
        if (rpt_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      rpt_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != IDLE);
      rpt_valid <= (state_nxt == REPORT);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y1_d     <= 1'b0;
      win_cnt  <= '0;
      cnt_zero <= '0;
      cnt_one  <= '0;
      cnt_diff <= '0;
      cnt_ill  <= '0;
      err      <= 1'b0;
    end else begin
      y1_d <= y1_in;
      if (state == IDLE && start) begin
        win_cnt  <= '0;
        cnt_zero <= '0;
        cnt_one  <= '0;
        cnt_diff <= '0;
        cnt_ill  <= '0;
        err      <= 1'b0;
      end else if (state == ACCUM) begin
        win_cnt <= win_cnt + 16'd1;
        // Counters stick at all-ones rather than wrapping.
        case (pair)
          2'b00: if (cnt_zero != CNT_MAX) cnt_zero <= cnt_zero + 1'b1;
          2'b01: if (cnt_one  != CNT_MAX) cnt_one  <= cnt_one + 1'b1;
          2'b10: if (cnt_diff != CNT_MAX) cnt_diff <= cnt_diff + 1'b1;
          default: begin
            if (cnt_ill != CNT_MAX) cnt_ill <= cnt_ill + 1'b1;
            err <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_pair_monitor.sv
// Bench for seq_pair_monitor: directed windows through a pair-generator model, scoreboarded reports.
module tb_seq_pair_monitor;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       y1_in, y2_in, start, rpt_ready;
  logic       busy, rpt_valid, err;
  logic [7:0] cnt_zero, cnt_one, cnt_diff, cnt_ill;
  logic [1:0] state_dbg;
  logic       start2, rpt_ready2, busy2, rpt_valid2, err2;
  logic [1:0] c2_zero, c2_one, c2_diff, c2_ill, state_dbg2;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic and_q;

  logic [32:0] exp_q[$];
  int          exp_lat_q[$];
  logic [8:0]  exp2_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  seq_pair_monitor #(.WINDOW(4), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .y1_in(y1_in), .y2_in(y2_in), .start(start),
    .rpt_ready(rpt_ready), .busy(busy), .rpt_valid(rpt_valid), .cnt_zero(cnt_zero),
    .cnt_one(cnt_one), .cnt_diff(cnt_diff), .cnt_ill(cnt_ill), .err(err), .state_dbg(state_dbg)
  );

  seq_pair_monitor #(.WINDOW(8), .CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .y1_in(y1_in), .y2_in(y2_in), .start(start2),
    .rpt_ready(rpt_ready2), .busy(busy2), .rpt_valid(rpt_valid2), .cnt_zero(c2_zero),
    .cnt_one(c2_one), .cnt_diff(c2_diff), .cnt_ill(c2_ill), .err(err2), .state_dbg(state_dbg2)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] pk(input int z, input int o, input int d, input int i, input logic e);
    return {e, 8'(i), 8'(d), 8'(o), 8'(z)};
  endfunction

  // ---------------- driver tasks ----------------
  // Reference pair generator: y1 = a^b now, y2 = a&b one cycle later.
  task automatic drive_pair(input logic a, input logic b, input logic st);
    y1_in = a ^ b;
    y2_in = and_q;
    start = st;
    @(posedge clk);
    and_q = a & b;
    #1;
  endtask

  task automatic drive_raw(input logic y1, input logic y2, input logic st);
    y1_in = y1;
    y2_in = y2;
    start = st;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      drive_pair(1'b0, 1'b0, 1'b0);
      if (!busy) return;
    end
    n_cmp++;
    n_fail++;
    $display("FAIL wait_idle: busy still %0b after %0d cycles", busy, max_cyc);
  endtask

  // ---------------- scoreboard monitors ----------------
  logic        prev_valid = 1'b0;
  logic        hs_pend    = 1'b0;
  int          start_cyc  = 0;
  logic [32:0] snap;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_valid = 1'b0;
      hs_pend    = 1'b0;
    end else begin
      if (hs_pend) begin
        chk("post_hs_rpt_valid", rpt_valid, 1'b0);
        chk("post_hs_busy", busy, 1'b0);
        hs_pend = 1'b0;
      end
      if (rpt_valid && !prev_valid) begin
        snap = {err, cnt_ill, cnt_diff, cnt_one, cnt_zero};
        if (exp_lat_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_report: rpt_valid with no expected latency queued");
        end else begin
          chk("report_latency", cyc - start_cyc, exp_lat_q.pop_front());
        end
      end else if (rpt_valid) begin
        chk("report_stable", {err, cnt_ill, cnt_diff, cnt_one, cnt_zero}, snap);
      end
      if (rpt_valid && rpt_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_handshake: no expected report queued");
        end else begin
          chk("report_counts", {err, cnt_ill, cnt_diff, cnt_one, cnt_zero}, exp_q.pop_front());
        end
        hs_pend = 1'b1;
      end
      if (start && !busy) start_cyc = cyc + 1;
      prev_valid = rpt_valid;
    end
  end

  always @(negedge clk) begin
    if (reset_n && rpt_valid2 && rpt_ready2) begin
      if (exp2_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_handshake2: no expected report queued");
      end else begin
        chk("report2_counts", {err2, c2_ill, c2_diff, c2_one, c2_zero}, exp2_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0; y1_in = 1'b0; y2_in = 1'b0; start = 1'b0; rpt_ready = 1'b1;
    start2 = 1'b0; rpt_ready2 = 1'b1; and_q = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_rpt_valid", rpt_valid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_counts", {cnt_ill, cnt_diff, cnt_one, cnt_zero}, 32'h0);
    chk("rst_state", state_dbg, 2'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic window: (0,0),(1,1),(0,1),(1,0) -> zero 1, one 1, diff 2.
    exp_lat_q.push_back(4);
    exp_q.push_back(pk(1, 1, 2, 0, 1'b0));
    drive_pair(1'b0, 1'b0, 1'b1);
    drive_pair(1'b1, 1'b1, 1'b0);
    drive_pair(1'b0, 1'b1, 1'b0);
    drive_pair(1'b1, 1'b0, 1'b0);
    wait_idle(20);

    // Raw illegal pair: y1=1 in ACCUM1, y2=1 in ACCUM2.
`ifdef SEQ_PAIR_MON_ERR_HALT_EN
    exp_lat_q.push_back(2);
    exp_q.push_back(pk(1, 0, 0, 1, 1'b1));
`else
    exp_lat_q.push_back(4);
    exp_q.push_back(pk(3, 0, 0, 1, 1'b1));
`endif
    drive_raw(1'b0, 1'b0, 1'b1);
    drive_raw(1'b1, 1'b0, 1'b0);
    drive_raw(1'b0, 1'b1, 1'b0);
    drive_raw(1'b0, 1'b0, 1'b0);
    drive_raw(1'b0, 1'b0, 1'b0);
    and_q = 1'b0;
    wait_idle(20);

    // Back-to-back: start in the first IDLE cycle; err and counts must restart.
    exp_lat_q.push_back(4);
    exp_q.push_back(pk(0, 2, 2, 0, 1'b0));
    drive_pair(1'b0, 1'b1, 1'b1);
    drive_pair(1'b1, 1'b1, 1'b0);
    drive_pair(1'b1, 1'b1, 1'b0);
    drive_pair(1'b1, 1'b0, 1'b0);
    wait_idle(20);

    // Backpressure: report held for 5 cycles while start pulses.
    rpt_ready = 1'b0;
    exp_lat_q.push_back(4);
    exp_q.push_back(pk(0, 4, 0, 0, 1'b0));
    for (int i = 0; i < 4; i++) drive_pair(1'b1, 1'b1, (i == 0));
    for (int i = 0; i < 10 && !rpt_valid; i++) drive_pair(1'b0, 1'b0, 1'b0);
    chk("bp_report_reached", rpt_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive_pair(1'b0, 1'b0, (i == 1 || i == 3));
      chk("bp_rpt_valid_held", rpt_valid, 1'b1);
      chk("bp_busy_held", busy, 1'b1);
    end
    rpt_ready = 1'b1;
    drive_pair(1'b0, 1'b0, 1'b1);
    chk("start_at_hs_ignored", busy, 1'b0);
    drive_pair(1'b0, 1'b0, 1'b0);
    chk("still_idle", busy, 1'b0);

    // Saturation on the narrow instance: 8 zero pairs into 2-bit counters.
    exp2_q.push_back({1'b0, 2'd0, 2'd0, 2'd0, 2'd3});
    start2 = 1'b1;
    drive_pair(1'b0, 1'b0, 1'b0);
    start2 = 1'b0;
    for (int i = 0; i < 12; i++) drive_pair(1'b0, 1'b0, 1'b0);
    chk("sat_busy2_done", busy2, 1'b0);

    // Reset mid-window after an illegal pair and a (1,1) pair have been counted.
`ifdef SEQ_PAIR_MON_ERR_HALT_EN
    exp_lat_q.push_back(1);
    exp_q.push_back(pk(0, 0, 0, 1, 1'b1));
`endif
    drive_raw(1'b1, 1'b0, 1'b1);
    drive_raw(1'b0, 1'b1, 1'b0);
    drive_raw(1'b0, 1'b1, 1'b0);
    chk("pre_reset_err", err, 1'b1);
    chk("pre_reset_ill", cnt_ill, 8'd1);
    reset_n = 1'b0;
    #1;
    chk("midrun_rst_busy", busy, 1'b0);
    chk("midrun_rst_rpt_valid", rpt_valid, 1'b0);
    chk("midrun_rst_err", err, 1'b0);
    chk("midrun_rst_counts", {cnt_ill, cnt_diff, cnt_one, cnt_zero}, 32'h0);
    @(negedge clk) reset_n = 1'b1;
    and_q = 1'b0;
    @(posedge clk);
    #1;
    drive_pair(1'b0, 1'b0, 1'b0);
    chk("post_rst_idle", busy, 1'b0);

    chk("exp_q_drained", exp_q.size(), 0);
    chk("exp_lat_q_drained", exp_lat_q.size(), 0);
    chk("exp2_q_drained", exp2_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
